// File: rtl/fp_pkg.sv
// Shared constants and bundle types for the float round-and-pack pipeline.
// Imported by the interface, the rounding helper and the pipeline top.
package fp_pkg;

  localparam int EXP_W = 3;
  localparam int SIG_W = 4;
  localparam int FP_W  = 8;

  localparam logic [EXP_W-1:0] EXP_MAX   = 3'b111;
  localparam logic [SIG_W-1:0] SIG_MAX   = 4'b1111;
  localparam logic [SIG_W-1:0] SIG_CARRY = 4'b1000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exponent;
    logic [SIG_W-1:0] significand;
    logic             round_up;
    logic             saturate;
  } stage_a_t;

  function automatic logic [FP_W-1:0] pack_fp(
    input logic             sign,
    input logic [EXP_W-1:0] exponent,
    input logic [SIG_W-1:0] significand
  );
    return {sign, exponent, significand};
  endfunction

endpackage

// File: rtl/fp_round_pack_if.sv
// Valid/ready bundle for the round-and-pack block: extract-side
// input handshake plus the packed-float output handshake.
interface fp_round_pack_if;
  import fp_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic             in_sign;
  logic [EXP_W-1:0] in_exponent;
  logic [SIG_W-1:0] in_significand;
  logic             in_fifth_bit;
  logic             out_valid;
  logic             out_ready;
  logic [FP_W-1:0]  out_fp;

  modport master (
    output in_valid, in_sign, in_exponent,
    output in_significand, in_fifth_bit,
    output out_ready,
    input  in_ready, out_valid, out_fp
  );

  modport slave (
    input  in_valid, in_sign, in_exponent,
    input  in_significand, in_fifth_bit,
    input  out_ready,
    output in_ready, out_valid, out_fp
  );

endinterface

// File: rtl/fp_round.sv
// Combinational round-half-up of a 3-bit exponent / 4-bit significand,
// carrying into the exponent and saturating at the largest value.
module fp_round
  import fp_pkg::*;
(
  input  logic [EXP_W-1:0] exponent,
  input  logic [SIG_W-1:0] significand,
  input  logic             fifth_bit,
  output logic [EXP_W-1:0] rnd_exponent,
  output logic [SIG_W-1:0] rnd_significand,
  output logic             round_up,
  output logic             saturate
);

  logic sig_full;
  logic exp_full;

  assign sig_full = (significand == SIG_MAX);
  assign exp_full = (exponent == EXP_MAX);

  // select one of pass / increment / carry / saturate
  always_comb begin
    rnd_exponent    = exponent;
    rnd_significand = significand;
    round_up        = fifth_bit;
    saturate        = 1'b0;
    unique case (1'b1)
      !fifth_bit: ;
      fifth_bit && !sig_full:
        rnd_significand = significand + 4'd1;
      fifth_bit && sig_full && !exp_full: begin
        rnd_exponent    = exponent + 3'd1;
        rnd_significand = SIG_CARRY;
      end
      default: begin
        rnd_exponent    = EXP_MAX;
        rnd_significand = SIG_MAX;
        saturate        = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/fp_round_pack.sv
// Two-stage round-and-pack pipeline with valid/ready flow control and
// saturating statistics of rounded and saturated deliveries.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  fp_round_pack_if.slave   bus,
  output logic [CNT_W-1:0] round_cnt,
  output logic [CNT_W-1:0] sat_cnt
);

  stage_a_t        a_d;
  stage_a_t        a_q;
  logic            a_valid;
  logic            a_adv;
  logic            b_valid;
  logic            b_adv;
  logic            b_rnd;
  logic            b_sat;
  logic [FP_W-1:0] b_fp;
  logic            out_hs;

  fp_round u_round (
    .exponent        (bus.in_exponent),
    .significand     (bus.in_significand),
    .fifth_bit       (bus.in_fifth_bit),
    .rnd_exponent    (a_d.exponent),
    .rnd_significand (a_d.significand),
    .round_up        (a_d.round_up),
    .saturate        (a_d.saturate)
  );

  assign a_d.sign     = bus.in_sign;
  assign b_adv        = !b_valid || bus.out_ready;
  assign a_adv        = !a_valid || b_adv;
  assign out_hs       = b_valid && bus.out_ready;
  assign bus.in_ready = rst || a_adv;
  assign bus.out_valid = b_valid;
  assign bus.out_fp   = b_fp;

  // stage A: capture the rounded fields when it can move on
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid <= 1'b0;
    end else if (a_adv) begin
      a_valid <= bus.in_valid;
      if (bus.in_valid) a_q <= a_d;
    end
  end

  // stage B: pack stage A into the output float
  always_ff @(posedge clk) begin
    if (rst) begin
      b_valid <= 1'b0;
      b_fp    <= '0;
      b_rnd   <= 1'b0;
      b_sat   <= 1'b0;
    end else if (b_adv) begin
      b_valid <= a_valid;
      if (a_valid) begin
        b_fp  <= pack_fp(a_q.sign, a_q.exponent,
                         a_q.significand);
        b_rnd <= a_q.round_up;
        b_sat <= a_q.saturate;
      end
    end
  end

  // statistics count on delivery and stick at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      round_cnt <= '0;
      sat_cnt   <= '0;
    end else if (out_hs) begin
      if (b_rnd && (round_cnt != '1))
        round_cnt <= round_cnt + CNT_W'(1);
      if (b_sat && (sat_cnt != '1))
        sat_cnt <= sat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fp_round_pack.sv
// Bench for fp_round_pack: directed literal cases plus random traffic
// against a queue-based reference model of the rounding and counters.
module tb_fp_round_pack;

  typedef struct {
    bit [7:0] fp;
    bit       rnd;
    bit       sat;
  } item_t;

  logic        clk;
  logic        rst;
  logic [15:0] round_cnt;
  logic [15:0] sat_cnt;
  logic [1:0]  rc2;
  logic [1:0]  sc2;

  int    n_chk;
  int    n_fail;
  int    m_rnd;
  int    m_sat;
  item_t exp_q[$];
  bit [7:0] dlv_q[$];

  fp_round_pack_if bus ();
  fp_round_pack_if bus2 ();

  fp_round_pack #(.CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .round_cnt (round_cnt),
    .sat_cnt   (sat_cnt)
  );

  fp_round_pack #(.CNT_W(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus2.slave),
    .round_cnt (rc2),
    .sat_cnt   (sc2)
  );

  assign bus2.in_valid       = bus.in_valid;
  assign bus2.in_sign        = bus.in_sign;
  assign bus2.in_exponent    = bus.in_exponent;
  assign bus2.in_significand = bus.in_significand;
  assign bus2.in_fifth_bit   = bus.in_fifth_bit;
  assign bus2.out_ready      = bus.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input longint got,
                     input longint want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t",
               name, got, want, $time);
    end
  endtask

  function automatic item_t model(input bit s,
                                  input bit [2:0] e,
                                  input bit [3:0] m,
                                  input bit f);
    item_t r;
    int ev;
    int mv;
    ev = e;
    mv = m;
    r.rnd = f;
    r.sat = 1'b0;
    if (f) begin
      if (mv < 15) mv = mv + 1;
      else if (ev < 7) begin
        ev = ev + 1;
        mv = 8;
      end else r.sat = 1'b1;
    end
    r.fp = {s, ev[2:0], mv[3:0]};
    return r;
  endfunction

  function automatic int sat_at(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic mon();
    item_t e;
    chk("round_cnt", round_cnt, sat_at(m_rnd, 65535));
    chk("sat_cnt", sat_cnt, sat_at(m_sat, 65535));
    chk("round_cnt_w2", rc2, sat_at(m_rnd, 3));
    chk("sat_cnt_w2", sc2, sat_at(m_sat, 3));
    if (rst) begin
      chk("rst_in_ready", bus.in_ready, 1);
      exp_q.delete();
      m_rnd = 0;
      m_sat = 0;
    end else begin
      chk("in_ready", bus.in_ready,
          (exp_q.size() < 2) || bus.out_ready);
      if (exp_q.size() == 0)
        chk("idle_valid", bus.out_valid, 0);
      if (bus.out_valid && bus.out_ready &&
          exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_fp", bus.out_fp, e.fp);
        dlv_q.push_back(bus.out_fp);
        if (e.rnd) m_rnd++;
        if (e.sat) m_sat++;
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.in_sign,
                              bus.in_exponent,
                              bus.in_significand,
                              bus.in_fifth_bit));
    end
  endtask

  task automatic push(input bit s, input bit [2:0] e,
                      input bit [3:0] m, input bit f);
    int n;
    n = 0;
    bus.in_valid       = 1'b1;
    bus.in_sign        = s;
    bus.in_exponent    = e;
    bus.in_significand = m;
    bus.in_fifth_bit   = f;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) chk("push_timeout", 1, 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic one(input string name, input bit s,
                     input bit [2:0] e, input bit [3:0] m,
                     input bit f, input bit [7:0] want);
    push(s, e, m, f);
    @(posedge clk);
    @(negedge clk);
    chk({name, "_valid"}, bus.out_valid, 1);
    chk({name, "_fp"}, bus.out_fp, want);
    @(posedge clk);
    @(negedge clk);
  endtask

  bit [7:0] bp_want[4];

  initial begin
    n_chk = 0;
    n_fail = 0;
    m_rnd = 0;
    m_sat = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sign = 1'b0;
    bus.in_exponent = '0;
    bus.in_significand = '0;
    bus.in_fifth_bit = 1'b0;
    bus.out_ready = 1'b1;
    fork
      forever begin
        @(negedge clk);
        mon();
      end
    join_none

    @(negedge clk);
    chk("reset_in_ready", bus.in_ready, 1);
    chk("reset_valid", bus.out_valid, 0);
    chk("reset_fp", bus.out_fp, 0);
    chk("reset_rcnt", round_cnt, 0);
    chk("reset_scnt", sat_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    one("roundup", 0, 3'b011, 4'b1011, 1, 8'h3C);
    chk("roundup_rcnt", round_cnt, 1);
    chk("roundup_scnt", sat_cnt, 0);
    @(posedge clk);
    #1;

    one("carry", 0, 3'b011, 4'b1111, 1, 8'h48);
    chk("carry_rcnt", round_cnt, 2);
    @(posedge clk);
    #1;

    do_reset();
    one("sat", 1, 3'b111, 4'b1111, 1, 8'hFF);
    chk("sat_scnt", sat_cnt, 1);
    chk("sat_rcnt", round_cnt, 1);
    @(posedge clk);
    #1;

    one("zero", 0, 3'b000, 4'b0000, 0, 8'h00);
    chk("zero_rcnt", round_cnt, 1);
    @(posedge clk);
    #1;

    bp_want[0] = 8'h12;
    bp_want[1] = 8'hA6;
    bp_want[2] = 8'h78;
    bp_want[3] = 8'h7F;
    dlv_q.delete();
    bus.out_ready = 1'b0;
    push(0, 3'b001, 4'b0010, 0);
    push(1, 3'b010, 4'b0101, 1);
    bus.in_valid       = 1'b1;
    bus.in_sign        = 1'b0;
    bus.in_exponent    = 3'b110;
    bus.in_significand = 4'b1111;
    bus.in_fifth_bit   = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_hold_valid", bus.out_valid, 1);
      chk("bp_hold_fp", bus.out_fp, 8'h12);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    push(0, 3'b110, 4'b1111, 1);
    push(0, 3'b111, 4'b1111, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("bp_count", dlv_q.size(), 4);
    if (dlv_q.size() == 4)
      for (int i = 0; i < 4; i++)
        chk("bp_order", dlv_q[i], bp_want[i]);
    @(posedge clk);
    #1;

    bus.out_ready = 1'b0;
    push(0, 3'b001, 4'b0001, 1);
    push(0, 3'b010, 4'b0010, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_flight_valid", bus.out_valid, 0);
    chk("rst_flight_rcnt", round_cnt, 0);
    chk("rst_flight_scnt", sat_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_valid", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;

    repeat (5) push(0, 3'b001, 4'b0011, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("cnt2_round_sat", rc2, 2'b11);
    chk("cnt16_round", round_cnt, 5);
    chk("cnt2_sat_zero", sc2, 0);
    @(posedge clk);
    #1;

    repeat (3000) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.in_sign = 1'($urandom);
      bus.in_exponent = ($urandom_range(0, 2) == 0) ?
                        3'b111 : 3'($urandom);
      bus.in_significand = ($urandom_range(0, 2) == 0) ?
                           4'b1111 : 4'($urandom);
      bus.in_fifth_bit = 1'($urandom);
      @(posedge clk);
      #1;
    end

    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_valid", bus.out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
